uart_buffered: RTL and testbench
================================

Name: uart_buffered

Overview:
- Buffered 8N1 UART that sits directly downstream of the j1b IO decode.
- Consumes the CPU-side strobes uart0_wr / uart0_rd / uart_w.
- Produces uart0_valid / uart0_data for the IO read mux.
- Drives and samples the physical serial pins; TX and RX FIFOs decouple the CPU from bit timing.

Parameters:
- BAUD_DIV, 416: clk cycles per serial bit; minimum 4.
- TX_AW, 4: log2 of TX FIFO depth (16 entries).
- RX_AW, 4: log2 of RX FIFO depth (16 entries).

Ports:
- clk  input  1  system clock; all state on rising edge.
- resetq  input  1  asynchronous active-low reset.
- uart0_wr  input  1  one-cycle strobe: push uart_w into TX FIFO.
- uart_w  input  8  TX byte, qualified by uart0_wr.
- uart0_rd  input  1  one-cycle strobe: pop RX FIFO head.
- uart0_valid  output  1  RX FIFO non-empty.
- uart0_data  output  8  RX FIFO head (show-ahead); 0 when empty.
- tx_full  output  1  TX FIFO full.
- rx_overrun  output  1  sticky: byte dropped because RX FIFO was full.
- rx_frame_err  output  1  sticky: stop bit sampled low.
- uart_tx  output  1  serial out, idle high.
- uart_rx  input  1  serial in, asynchronous to clk.

Behaviour:
- Reset (async, resetq=0):
  - Outputs: uart_tx=1, uart0_valid=0, uart0_data=0, tx_full=0, rx_overrun=0, rx_frame_err=0.
  - Internal: both FIFOs empty, both FSMs IDLE, synchronizer flops=1.
  - Reset mid-frame aborts the frame; uart_tx goes high immediately.
  - Sticky flags clear only on reset.
- FIFOs:
  - Binary pointers with one extra wrap bit; full/empty from registered pointers.
  - Push when full is dropped silently. The full decision uses pre-edge state, so a push coinciding with a pop while full is still dropped.
  - Pop when empty is ignored.
  - On RX, a simultaneous push and pop while non-empty leaves count unchanged.
- TX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: when TX FIFO is non-empty, pop into an 8-bit shift register and enter START; uart_tx=0 from the next edge.
  - Each state lasts BAUD_DIV cycles, timed by a down-counter reloaded with BAUD_DIV-1.
  - DATA shifts out 8 bits LSB first, driving uart_tx = shift[0].
  - STOP drives uart_tx=1. At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
  - Frame length is exactly 10*BAUD_DIV cycles.
- RX path:
  - Synchronizer: uart_rx passes through a 2-flop synchronizer (rxs).
  - IDLE: rxs=0 -> START; wait BAUD_DIV/2 cycles (integer division) to reach mid-start.
  - START: if rxs=1 at mid-start, treat as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits at BAUD_DIV intervals, LSB first.
  - STOP, sampled one BAUD_DIV after the last data bit:
    - rxs=1 and FIFO not full: push the byte.
    - rxs=1 and FIFO full: drop the byte and set rx_overrun.
    - rxs=0: drop the byte, set rx_frame_err, enter WAITHI until rxs=1, then IDLE.
  - A pushed byte is visible on uart0_valid/uart0_data on the cycle after the stop sample.
- Widths: counters are sized with clog2(BAUD_DIV); no arithmetic wraps within a frame.

Test Plan:
- All scenarios use BAUD_DIV=4.
- Single TX: one uart0_wr with 0x55 at cycle 0 -> uart_tx=0 for cycles 2-5, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, stop high for 4 cycles, then idle high; total frame 40 cycles.
- TX burst: 20 consecutive uart0_wr of 0x00..0x13 -> first 17 accepted (one in the shifter, 16 queued); tx_full=1 after the 17th; 0x11..0x13 dropped; serial stream carries 0x00..0x10 in order with no idle gaps.
- RX byte: drive a 0xA3 frame on uart_rx -> uart0_valid=1 and uart0_data=0xA3 about 3 cycles after the stop midpoint; pulse uart0_rd -> uart0_valid=0 next cycle; a uart0_rd while empty leaves state unchanged.
- RX glitch / framing: a 1-cycle low pulse on uart_rx -> no byte, no flags set. A 0x3C frame with the stop bit held low -> no byte, rx_frame_err=1; the next good frame 0x7E is still received.
- RX overrun: 17 good frames 0x01..0x11 with no reads -> FIFO holds 0x01..0x10; rx_overrun=1; 16 reads return 0x01..0x10 in order; uart0_valid then falls to 0.
- Reset mid-TX: assert resetq=0 during DATA of 0xF0 -> uart_tx=1 immediately; tx_full=0; after release, no residual frame appears and a new write transmits correctly.

Source files
------------

// File: rtl/uart_buffered.sv
// uart_buffered: buffered 8N1 UART sitting behind the j1b IO decode.
//   clk, resetq              : clock, async active-low reset
//   uart0_wr, uart_w[7:0]    : push a byte into the TX FIFO (dropped when full)
//   uart0_rd                 : pop the RX FIFO head (ignored when empty)
//   uart0_valid, uart0_data  : RX FIFO non-empty / show-ahead head (0 when empty)
//   tx_full                  : TX FIFO full
//   rx_overrun, rx_frame_err : sticky error flags, cleared only by reset
//   uart_tx, uart_rx         : serial pins (uart_rx is asynchronous to clk)

// Show-ahead FIFO, 2**AW entries, binary pointers with a wrap bit.
//   push/din, pop, dout, empty, full
module uart_buffered_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  logic [7:0]  mem [0:(1<<AW)-1];
  logic [AW:0] wp, rp;
  logic        do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  // full/empty come from registered pointers, so a push colliding with a
  // pop while full is still refused.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end

  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

module uart_buffered #(
  parameter int BAUD_DIV = 416,
  parameter int TX_AW    = 4,
  parameter int RX_AW    = 4
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       uart0_wr,
  input  logic [7:0] uart_w,
  input  logic       uart0_rd,
  output logic       uart0_valid,
  output logic [7:0] uart0_data,
  output logic       tx_full,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       uart_tx,
  input  logic       uart_rx
);
  localparam int CW = $clog2(BAUD_DIV);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t RELOAD = cnt_t'(BAUD_DIV - 1);
  localparam cnt_t HALF   = cnt_t'(BAUD_DIV / 2 - 1);

  // ---------------- TX ----------------
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;
  tx_st_t     tx_st, tx_st_n;
  cnt_t       tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic       tx_pop, tx_empty;
  logic [7:0] tx_dout;

  uart_buffered_fifo #(.AW(TX_AW)) u_txq (
    .clk(clk), .rst_n(resetq), .push(uart0_wr), .din(uart_w),
    .pop(tx_pop), .dout(tx_dout), .empty(tx_empty), .full(tx_full));

  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      tx_st  <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh  <= tx_sh_n;
    end

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_pop   = 1'b0;
    case (tx_st)
      T_IDLE:
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_n  = tx_dout;
          tx_cnt_n = RELOAD;
          tx_st_n  = T_START;
        end
      T_START:
        if (tx_cnt == '0) begin
          tx_cnt_n = RELOAD;
          tx_bit_n = '0;
          tx_st_n  = T_DATA;
        end else tx_cnt_n = tx_cnt - cnt_t'(1);
      T_DATA:
        if (tx_cnt == '0) begin
          tx_cnt_n = RELOAD;
          if (tx_bit == 3'd7) tx_st_n = T_STOP;
          else begin
            tx_bit_n = tx_bit + 3'd1;
            tx_sh_n  = {1'b0, tx_sh[7:1]};
          end
        end else tx_cnt_n = tx_cnt - cnt_t'(1);
      T_STOP:
        if (tx_cnt == '0) begin
          // Back-to-back frames: reload straight into START, no idle bit.
          if (!tx_empty) begin
            tx_pop   = 1'b1;
            tx_sh_n  = tx_dout;
            tx_cnt_n = RELOAD;
            tx_st_n  = T_START;
          end else tx_st_n = T_IDLE;
        end else tx_cnt_n = tx_cnt - cnt_t'(1);
      default: tx_st_n = T_IDLE;
    endcase
  end

  // Decoded from state flops only, so reset forces the line high at once.
  assign uart_tx = (tx_st == T_START) ? 1'b0 :
                   (tx_st == T_DATA)  ? tx_sh[0] : 1'b1;

  // ---------------- RX ----------------
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_st_t;
  rx_st_t     rx_st, rx_st_n;
  cnt_t       rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n;
  logic [1:0] rx_sync;
  logic       rxs;
  logic       rx_push, rx_full, rx_empty, set_ovr, set_ferr;
  logic [7:0] rx_dout;

  assign rxs = rx_sync[1];

  uart_buffered_fifo #(.AW(RX_AW)) u_rxq (
    .clk(clk), .rst_n(resetq), .push(rx_push), .din(rx_sh),
    .pop(uart0_rd), .dout(rx_dout), .empty(rx_empty), .full(rx_full));

  assign uart0_valid = ~rx_empty;
  assign uart0_data  = rx_empty ? 8'h00 : rx_dout;

  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      rx_sync      <= 2'b11;
      rx_st        <= R_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync      <= {rx_sync[0], uart_rx};
      rx_st        <= rx_st_n;
      rx_cnt       <= rx_cnt_n;
      rx_bit       <= rx_bit_n;
      rx_sh        <= rx_sh_n;
      rx_overrun   <= rx_overrun | set_ovr;
      rx_frame_err <= rx_frame_err | set_ferr;
    end

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_push  = 1'b0;
    set_ovr  = 1'b0;
    set_ferr = 1'b0;
    case (rx_st)
      R_IDLE:
        if (!rxs) begin
          rx_cnt_n = HALF;
          rx_st_n  = R_START;
        end
      R_START:
        if (rx_cnt == '0) begin
          if (rxs) rx_st_n = R_IDLE;   // start bit gone by mid-bit: glitch
          else begin
            rx_cnt_n = RELOAD;
            rx_bit_n = '0;
            rx_st_n  = R_DATA;
          end
        end else rx_cnt_n = rx_cnt - cnt_t'(1);
      R_DATA:
        if (rx_cnt == '0) begin
          rx_sh_n  = {rxs, rx_sh[7:1]};
          rx_cnt_n = RELOAD;
          if (rx_bit == 3'd7) rx_st_n = R_STOP;
          else rx_bit_n = rx_bit + 3'd1;
        end else rx_cnt_n = rx_cnt - cnt_t'(1);
      R_STOP:
        if (rx_cnt == '0) begin
          if (rxs) begin
            if (rx_full) set_ovr = 1'b1;
            else rx_push = 1'b1;
            rx_st_n = R_IDLE;
          end else begin
            set_ferr = 1'b1;
            rx_st_n  = R_WAITHI;
          end
        end else rx_cnt_n = rx_cnt - cnt_t'(1);
      R_WAITHI:
        if (rxs) rx_st_n = R_IDLE;
      default: rx_st_n = R_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_buffered.sv
// Self-checking bench for uart_buffered at BAUD_DIV=4. The serial side is
// modelled as an ideal 8N1 line: frames are built/decoded from bit timing
// and compared with byte queues.
module tb_uart_buffered;
  localparam int BD    = 4;
  localparam int TX_AW = 4;
  localparam int RX_AW = 4;

  logic       clk = 1'b0;
  logic       resetq, uart0_wr, uart0_rd, uart_rx;
  logic [7:0] uart_w;
  logic       uart0_valid, tx_full, rx_overrun, rx_frame_err, uart_tx;
  logic [7:0] uart0_data;
  int         cyc = 0;
  int         n_chk = 0, n_err = 0;

  uart_buffered #(.BAUD_DIV(BD), .TX_AW(TX_AW), .RX_AW(RX_AW)) dut (
    .clk(clk), .resetq(resetq), .uart0_wr(uart0_wr), .uart_w(uart_w),
    .uart0_rd(uart0_rd), .uart0_valid(uart0_valid), .uart0_data(uart0_data),
    .tx_full(tx_full), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
    .uart_tx(uart_tx), .uart_rx(uart_rx));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode one frame from uart_tx. t0 = cycle of the first start-bit cycle.
  task automatic tx_get(output logic [7:0] b, output int t0, output bit ok);
    ok = 1'b0;
    b  = '0;
    t0 = 0;
    for (int w = 0; w < 3000; w++) begin
      tick();
      if (uart_tx == 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    t0 = cyc;
    repeat (BD/2) tick();
    chk("tx_start_mid", uart_tx, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) tick();
      b[i] = uart_tx;
    end
    repeat (BD) tick();
    chk("tx_stop", uart_tx, 1);
    repeat (BD/2 - 1) tick();
  endtask

  // Drive one frame on uart_rx, then 4 idle-high cycles.
  task automatic rx_send(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BD) tick();
    end
    uart_rx = stop_ok;
    repeat (BD) tick();
    uart_rx = 1'b1;
    repeat (4) tick();
  endtask

  task automatic rd_pulse();
    uart0_rd = 1'b1;
    tick();
    uart0_rd = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    uart0_wr = 1'b1;
    uart_w   = b;
    tick();
    uart0_wr = 1'b0;
  endtask

  initial begin
    logic [7:0] b, frame_bits;
    logic [9:0] frame;
    logic       ovr_exp;
    int         t0, tp, lows;
    bit         ok;
    logic [7:0] acc[$], got[$], mq[$];

    resetq = 1'b0; uart0_wr = 1'b0; uart0_rd = 1'b0; uart_rx = 1'b1; uart_w = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", uart_tx, 1);
    chk("rst_valid", uart0_valid, 0);
    chk("rst_data", uart0_data, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_ovr", rx_overrun, 0);
    chk("rst_ferr", rx_frame_err, 0);
    resetq = 1'b1;
    repeat (4) tick();

    // Single TX 0x55: line low cycles 2..5, data LSB first, stop, idle.
    frame_bits = 8'h55;
    frame = {1'b1, frame_bits, 1'b0};
    wr_byte(8'h55);
    for (int c = 1; c <= 45; c++) begin
      logic e;
      e = (c < 2 || c >= 2 + 10*BD) ? 1'b1 : frame[(c-2)/BD];
      chk($sformatf("tx55_c%0d", c), uart_tx, e);
      tick();
    end

    // TX burst of 20 consecutive writes; line holds 16 queued + 1 shifting.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          uart0_wr = 1'b1;
          uart_w   = 8'(i);
          if (acc.size() < 1 + (1 << TX_AW)) acc.push_back(8'(i));
          tick();
          if (i == 15) chk("txfull_15", tx_full, 0);
          if (i == 16) chk("txfull_16", tx_full, 1);
        end
        uart0_wr = 1'b0;
      end
      begin
        tp = 0;
        for (int k = 0; k < 17; k++) begin
          tx_get(b, t0, ok);
          chk("burst_found", ok, 1);
          if (k > 0) chk("burst_gap", t0 - tp, 10*BD);
          tp = t0;
          got.push_back(b);
        end
      end
    join
    chk("burst_cnt", got.size(), acc.size());
    for (int k = 0; k < acc.size() && k < got.size(); k++)
      chk($sformatf("burst_b%0d", k), got[k], acc[k]);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (!uart_tx) lows++;
      tick();
    end
    chk("burst_idle", lows, 0);
    chk("burst_full_clr", tx_full, 0);

    // Random single-byte TX
    for (int k = 0; k < 3; k++) begin
      logic [7:0] r;
      r = 8'($urandom);
      wr_byte(r);
      tx_get(b, t0, ok);
      chk("rtx_found", ok, 1);
      chk("rtx_byte", b, r);
    end

    // RX byte 0xA3, pop, pop-while-empty
    rx_send(8'hA3, 1'b1);
    chk("rx_valid", uart0_valid, 1);
    chk("rx_data", uart0_data, 8'hA3);
    rd_pulse();
    chk("rx_pop_valid", uart0_valid, 0);
    chk("rx_pop_data", uart0_data, 0);
    rd_pulse();
    chk("rx_emptyrd_valid", uart0_valid, 0);
    chk("rx_emptyrd_ovr", rx_overrun, 0);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] r;
      r = 8'($urandom);
      rx_send(r, 1'b1);
      chk("rrx_data", uart0_data, r);
      rd_pulse();
    end

    // Glitch: one-cycle low pulse
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    chk("glitch_valid", uart0_valid, 0);
    chk("glitch_ovr", rx_overrun, 0);
    chk("glitch_ferr", rx_frame_err, 0);

    // Framing error then recovery
    rx_send(8'h3C, 1'b0);
    chk("ferr_valid", uart0_valid, 0);
    chk("ferr_flag", rx_frame_err, 1);
    rx_send(8'h7E, 1'b1);
    chk("ferr_next_valid", uart0_valid, 1);
    chk("ferr_next_data", uart0_data, 8'h7E);
    rd_pulse();

    // Overrun: 17 frames, no reads
    ovr_exp = 1'b0;
    for (int k = 0; k < 17; k++) begin
      logic [7:0] r;
      r = (k == 0) ? 8'h01 : 8'($urandom);
      rx_send(r, 1'b1);
      if (mq.size() < (1 << RX_AW)) mq.push_back(r);
      else ovr_exp = 1'b1;
    end
    chk("ovr_flag", rx_overrun, ovr_exp);
    for (int k = 0; k < 16; k++) begin
      chk("ovr_rd_valid", uart0_valid, 1);
      chk($sformatf("ovr_rd_%0d", k), uart0_data, mq.pop_front());
      rd_pulse();
    end
    chk("ovr_drain_valid", uart0_valid, 0);
    chk("ovr_drain_data", uart0_data, 0);
    chk("ferr_sticky", rx_frame_err, 1);
    chk("ovr_sticky", rx_overrun, 1);

    // Reset in the middle of a 0xF0 frame
    wr_byte(8'hF0);
    repeat (14) tick();
    resetq = 1'b0;
    #1;
    chk("mrst_tx", uart_tx, 1);
    chk("mrst_full", tx_full, 0);
    chk("mrst_ovr", rx_overrun, 0);
    chk("mrst_ferr", rx_frame_err, 0);
    repeat (2) @(posedge clk);
    #1;
    resetq = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (!uart_tx) lows++;
      tick();
    end
    chk("mrst_no_residue", lows, 0);
    begin
      logic [7:0] r;
      r = 8'($urandom);
      wr_byte(r);
      tx_get(b, t0, ok);
      chk("mrst_found", ok, 1);
      chk("mrst_byte", b, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
